// File: rtl/apb_reg_bank.sv
// apb_reg_bank: APB3 register bank with wait states, PSLVERR, write lock and per-register write pulses.
// Define APB_PSTRB_EN to add the PSTRB port and byte-lane writes.
module apb_reg_bank #(
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD = 32,
  parameter int NUM_REGS = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AMBA_ADDR_WIDTH-1:0]    PADDR,
  input  logic [AMBA_WORD-1:0]          PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [AMBA_WORD/8-1:0]        PSTRB,
`endif
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  input  logic                          lock_i,
  output logic [AMBA_WORD-1:0]          PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  output logic [NUM_REGS*AMBA_WORD-1:0] regs_o,
  output logic [NUM_REGS-1:0]           wr_pulse
);
  localparam int IDXW = $clog2(NUM_REGS);
  localparam logic [AMBA_ADDR_WIDTH-1:0] LIMIT = AMBA_ADDR_WIDTH'(4 * NUM_REGS);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state;
  logic [2:0] cnt;
  logic [IDXW-1:0] idx;
  logic [AMBA_WORD-1:0] regs [NUM_REGS];
  logic [AMBA_WORD-1:0] mask;
  logic any, err, wr;
`ifdef APB_PSTRB_EN
  for (genvar b = 0; b < AMBA_WORD / 8; b++) begin : g_mask
    assign mask[b*8 +: 8] = {8{PSTRB[b]}};
  end
  assign any = |PSTRB;
`else
  assign mask = '1;
  assign any = 1'b1;
`endif
  assign idx = PADDR[IDXW+1:2];
  assign err = (PADDR[1:0] != 2'b00) | (PADDR >= LIMIT) | (PWRITE & lock_i);
  assign PREADY = (state == ACCESS) & PSEL & PENABLE & (cnt == 3'd0);
  assign PSLVERR = PREADY & err;
  assign PRDATA = (PREADY & ~PWRITE & ~err) ? regs[idx] : '0;
  // An all-zero strobe completes cleanly but must not touch the register or pulse.
  assign wr = PREADY & PWRITE & ~err & any;
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign regs_o[k*AMBA_WORD +: AMBA_WORD] = regs[k];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= 3'd0;
      wr_pulse <= '0;
      regs <= '{default: '0};
    end else begin
      wr_pulse <= '0;
      if (wr) begin
        regs[idx] <= (regs[idx] & ~mask) | (PWDATA & mask);
        wr_pulse[idx] <= 1'b1;
      end
      if (state == IDLE) begin
        if (PSEL & ~PENABLE) begin
          state <= ACCESS;
          cnt <= 3'(WAIT_STATES);
        end
      end else if (~PSEL | PREADY) begin
        state <= IDLE;
      end else if (PENABLE) begin
        cnt <= cnt - 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_apb_reg_bank.sv
// tb_apb_reg_bank: directed APB transfers on three banks (0, 2 and 3 wait states) sharing one bus,
// checked every cycle against a transaction-level model of the registers and handshake timing.
`timescale 1ns/1ps
module tb_apb_reg_bank;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [19:0] paddr;
  logic [31:0] pwdata;
  logic [3:0] pstrb;
  logic psel, penable, pwrite, lock;
  int sel;
  logic [31:0] prdata [3];
  logic pready [3];
  logic pslverr [3];
  logic [127:0] regs [3];
  logic [3:0] wrp [3];
  logic [31:0] mreg [3][4];
  logic [3:0] mpulse [3];
  int cur, acc_n;
  bit in_acc;
  logic exp_err;
  logic [31:0] exp_rd;
  int nvec = 0;
  int nbad = 0;
`ifdef APB_PSTRB_EN
  localparam bit STRB = 1'b1;
`else
  localparam bit STRB = 1'b0;
`endif
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_reg_bank #(.WAIT_STATES(g == 0 ? 0 : g == 1 ? 2 : 3)) dut (
      .clk(clk), .rst(rst), .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_PSTRB_EN
      .PSTRB(pstrb),
`endif
      .PSEL(psel && sel == g), .PENABLE(penable), .PWRITE(pwrite), .lock_i(lock),
      .PRDATA(prdata[g]), .PREADY(pready[g]), .PSLVERR(pslverr[g]),
      .regs_o(regs[g]), .wr_pulse(wrp[g])
    );
  end
  function automatic int ws_of(input int k);
    return k == 0 ? 0 : k == 1 ? 2 : 3;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mpulse[k] = 4'b0;
      for (int j = 0; j < 4; j++) mreg[k][j] = 32'h0;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) mpulse[k] = 4'b0;
  endtask
  always @(negedge clk) begin
    bit r;
    for (int k = 0; k < 3; k++) begin
      r = rst && in_acc && cur == k && acc_n == ws_of(k);
      chk($sformatf("pready%0d", k), 32'(pready[k]), 32'(r));
      chk($sformatf("pslverr%0d", k), 32'(pslverr[k]), 32'(r && exp_err));
      chk($sformatf("prdata%0d", k), prdata[k], r ? exp_rd : 32'h0);
      chk($sformatf("wr_pulse%0d", k), 32'(wrp[k]), 32'(mpulse[k]));
      for (int j = 0; j < 4; j++)
        chk($sformatf("reg%0d_%0d", k, j), regs[k][j*32 +: 32], mreg[k][j]);
    end
  end
  task automatic apb(input int s, input logic [19:0] a, input logic [31:0] d, input bit w,
                     input logic [3:0] st, input bit b2b,
                     output logic [31:0] rd, output bit e, output int lat);
    logic [31:0] m;
    bit er;
    int idx;
    if (!b2b) tick();
    sel = s; paddr = a; pwdata = d; pwrite = w; pstrb = st; psel = 1'b1; penable = 1'b0;
    er = (a[1:0] != 2'b00) || (a >= 20'd16) || (w && lock);
    idx = int'(a[3:2]);
    exp_err = er;
    exp_rd = (w || er) ? 32'h0 : mreg[s][idx];
    tick();
    penable = 1'b1; cur = s; in_acc = 1'b1; acc_n = 0; lat = 0;
    forever begin
      @(negedge clk);
      if (pready[s]) break;
      lat++;
      if (lat > 20) begin
        nvec++; nbad++;
        $display("FAIL timeout: no PREADY from bank %0d", s);
        break;
      end
      tick();
      acc_n++;
    end
    rd = prdata[s];
    e = pslverr[s];
    tick();
    in_acc = 1'b0; psel = 1'b0; penable = 1'b0;
    m = STRB ? {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}} : 32'hFFFFFFFF;
    if (w && !er && m != 32'h0) begin
      mreg[s][idx] = (mreg[s][idx] & ~m) | (d & m);
      mpulse[s][idx] = 1'b1;
    end
  endtask
  initial begin
    logic [31:0] rd;
    bit e;
    int lat;
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 4'hF; lock = 0; sel = 0;
    in_acc = 0; cur = 0; acc_n = 0; exp_err = 0; exp_rd = 0;
    model_reset();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    apb(0, 20'h8, 32'h12345678, 1, 4'hF, 0, rd, e, lat);
    chk("t2_wlat", 32'(lat), 32'd0);
    chk("t2_reg2", regs[0][95:64], 32'h12345678);
    chk("t2_pulse", 32'(wrp[0]), 32'h4);
    apb(0, 20'h8, 32'h0, 0, 4'hF, 1, rd, e, lat);
    chk("t2_rdata", rd, 32'h12345678);
    chk("t2_rlat", 32'(lat), 32'd0);
    apb(1, 20'h0, 32'h0, 0, 4'hF, 0, rd, e, lat);
    chk("t3_lat", 32'(lat), 32'd2);
    chk("t3_rdata", rd, 32'h0);
    apb(1, 20'hC, 32'hCAFEF00D, 1, 4'hF, 0, rd, e, lat);
    apb(1, 20'hC, 32'h0, 0, 4'hF, 1, rd, e, lat);
    chk("t3_rdata2", rd, 32'hCAFEF00D);
    apb(0, 20'h10, 32'h11111111, 1, 4'hF, 0, rd, e, lat);
    chk("t4_err_range", 32'(e), 32'd1);
    apb(0, 20'h2, 32'h22222222, 1, 4'hF, 0, rd, e, lat);
    chk("t4_err_align", 32'(e), 32'd1);
    chk("t4_reg0", regs[0][31:0], 32'h0);
    chk("t4_reg2", regs[0][95:64], 32'h12345678);
    apb(0, 20'h11, 32'h0, 0, 4'hF, 0, rd, e, lat);
    chk("t4_rd_err", 32'(e), 32'd1);
    chk("t4_rd_data", rd, 32'h0);
    apb(0, 20'h0, 32'hA5A5A5A5, 1, 4'hF, 0, rd, e, lat);
    lock = 1'b1;
    apb(0, 20'h0, 32'h55, 1, 4'hF, 0, rd, e, lat);
    chk("t5_lock_err", 32'(e), 32'd1);
    chk("t5_reg0", regs[0][31:0], 32'hA5A5A5A5);
    apb(0, 20'h0, 32'h0, 0, 4'hF, 0, rd, e, lat);
    chk("t5_rd_err", 32'(e), 32'd0);
    chk("t5_rdata", rd, 32'hA5A5A5A5);
    lock = 1'b0;
`ifdef APB_PSTRB_EN
    apb(0, 20'hC, 32'hFFFFFFFF, 1, 4'hF, 0, rd, e, lat);
    apb(0, 20'hC, 32'h0, 1, 4'b0101, 0, rd, e, lat);
    chk("t6_reg3", regs[0][127:96], 32'hFF00FF00);
    apb(0, 20'hC, 32'h0, 1, 4'b0000, 0, rd, e, lat);
    chk("t6_nostrb_err", 32'(e), 32'd0);
    chk("t6_nostrb_reg3", regs[0][127:96], 32'hFF00FF00);
`endif
    apb(2, 20'h4, 32'h0BADF00D, 1, 4'hF, 0, rd, e, lat);
    chk("t1_lat", 32'(lat), 32'd3);
    chk("t1_reg1_pre", regs[2][63:32], 32'h0BADF00D);
    tick();
    sel = 2; paddr = 20'h4; pwdata = 32'hDEADBEEF; pwrite = 1; psel = 1; penable = 0;
    exp_err = 0; exp_rd = 0;
    tick();
    penable = 1; cur = 2; in_acc = 1; acc_n = 0;
    tick();
    acc_n = 1;
    #2;
    rst = 1'b0;
    in_acc = 0;
    model_reset();
    #1;
    psel = 0; penable = 0;
    tick();
    chk("t1_reg1", regs[2][63:32], 32'h0);
    chk("t1_pulse", 32'(wrp[2]), 32'h0);
    rst = 1'b1;
    tick();
    apb(2, 20'h4, 32'h0, 0, 4'hF, 0, rd, e, lat);
    chk("t1_idle_lat", 32'(lat), 32'd3);
    chk("t1_rdata", rd, 32'h0);
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
